// File: rtl/pulse_count_rx.sv
// rtl/pulse_count_rx.sv - gated pulse-train receiver: counts synchronized rising edges, ends on quiet interval
// Optional glitch filter: define GLITCH_FILTER_EN.
module pulse_count_rx #(
    parameter int CW            = 8,
    parameter int EXPECT        = 4,
    parameter int IDLE_CYCLES   = 16,
    parameter int START_TIMEOUT = 1024,
    parameter int FILT_LEN      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          pin,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          match,
    output logic          timeout,
    output logic          overflow
);

    localparam int TMAX = (IDLE_CYCLES > START_TIMEOUT) ? IDLE_CYCLES : START_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_EXP    = CW'(EXPECT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_COUNTING,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            match_q, match_d;
    logic            timeout_q, timeout_d;
    logic            overflow_q, overflow_d;
    logic            s1_q, s3_q;
    logic            lvl;
    logic            rise;

`ifdef GLITCH_FILTER_EN
    // The filter flop takes the place of the second synchronizer stage, so
    // its run counter observes s1 directly and adds only FILT_LEN-1 cycles.
    localparam int RW = $clog2(FILT_LEN + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(FILT_LEN - 1);

    logic          filt_q, filt_d;
    logic [RW-1:0] run_q, run_d;

    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (s1_q != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = s1_q;
            end else begin
                run_d = run_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign lvl = filt_q;
`else
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= 1'b0;
        end else begin
            s2_q <= s1_q;
        end
    end

    assign lvl = s2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pin;
            s3_q <= lvl;
        end
    end

    assign rise = lvl & ~s3_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = timer_q + TW'(1);
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        match_d    = match_q;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (arm) begin
                    count_d    = '0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                    match_d    = 1'b0;
                    state_d    = S_WAIT_FIRST;
                end
            end
            S_WAIT_FIRST: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    count_d = CW'(1);
                    state_d = S_COUNTING;
                end else if (timer_q == START_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_COUNTING: begin
                // An edge on the expiry cycle still counts and restarts the timer.
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    timer_d = '0;
                    if (count_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (timer_q == IDLE_LAST) begin
                    match_d = (count_q == CNT_EXP) && !overflow_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
        if (state_d == S_IDLE) begin
            match_d = 1'b0;
        end

        busy_d = (state_d == S_WAIT_FIRST) || (state_d == S_COUNTING);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            match_q    <= match_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign match    = match_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_count_rx.sv
// tb/tb_pulse_count_rx.sv - randomized self-checking bench for pulse_count_rx against a pulse-list model
module tb_pulse_count_rx;

    localparam int CW            = 8;
    localparam int EXPECT        = 4;
    localparam int IDLE_CYCLES   = 16;
    localparam int START_TIMEOUT = 1024;
    localparam int FILT_LEN      = 2;
    localparam int CNT_SAT       = (1 << CW) - 1;
`ifdef GLITCH_FILTER_EN
    localparam int MINW = FILT_LEN;
`else
    localparam int MINW = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic          pin;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic          match;
    logic          timeout;
    logic          overflow;

    always #5 clk = ~clk;

    pulse_count_rx #(
        .CW(CW), .EXPECT(EXPECT), .IDLE_CYCLES(IDLE_CYCLES),
        .START_TIMEOUT(START_TIMEOUT), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .pin(pin),
        .count(count), .busy(busy), .done(done), .match(match),
        .timeout(timeout), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle stamps of the last count change and the last done rise.
    int            cyc = 0;
    int            last_chg = 0;
    int            done_at = 0;
    logic [CW-1:0] prev_cnt;
    logic          prev_done = 1'b0;

    always @(negedge clk) begin
        if (count !== prev_cnt) last_chg <= cyc;
        if (done && !prev_done) done_at <= cyc;
        prev_cnt  <= count;
        prev_done <= done;
        cyc       <= cyc + 1;
    end

    int hi_q[$];
    int lo_q[$];
    int lead;

    // Pulses are accepted when wide enough; the train ends once the spacing
    // between accepted rises exceeds IDLE_CYCLES; later pulses are ignored.
    task automatic model(output int cnt, output bit ovf);
        int  t;
        int  last;
        bit  ended;
        t = lead; last = -1; ended = 0; cnt = 0; ovf = 0;
        foreach (hi_q[i]) begin
            if (!ended && hi_q[i] >= MINW) begin
                if (last >= 0 && t - last > IDLE_CYCLES) begin
                    ended = 1;
                end else begin
                    if (cnt == CNT_SAT) ovf = 1;
                    else cnt++;
                    last = t;
                end
            end
            t += hi_q[i] + lo_q[i];
        end
    endtask

    task automatic send_pulses();
        foreach (hi_q[i]) begin
            pin = 1'b1;
            repeat (hi_q[i]) @(negedge clk);
            pin = 1'b0;
            repeat (lo_q[i]) @(negedge clk);
        end
    endtask

    task automatic disarm();
        arm = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_train(input string tag);
        int ecnt;
        bit eovf;
        int n;
        model(ecnt, eovf);
        arm = 1'b1;
        repeat (lead) @(negedge clk);
        send_pulses();
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_count"}, count, ecnt);
        check({tag, "_overflow"}, overflow, eovf);
        check({tag, "_timeout"}, timeout, (ecnt == 0));
        check({tag, "_match"}, match, (ecnt == EXPECT) && !eovf);
        check({tag, "_busy"}, busy, 0);
        if (ecnt > 0 && !eovf)
            check({tag, "_idle_gap"}, done_at - last_chg, IDLE_CYCLES);
        disarm();
    endtask

    task automatic fill(input int n, input int hi, input int lo);
        hi_q.delete();
        lo_q.delete();
        for (int i = 0; i < n; i++) begin
            hi_q.push_back(hi);
            lo_q.push_back(lo);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        arm   = 1'b0;
        pin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_timeout", timeout, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        lead = 5;
        fill(4, 2, 2);
        run_train("basic4");

        arm = 1'b1;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) check("to_busy", busy, 1);
        end
        check("to_latency", n, START_TIMEOUT + 1);
        check("to_timeout", timeout, 1);
        check("to_count", count, 0);
        check("to_match", match, 0);
        disarm();

        lead = 3;
        fill(300, 2, 2);
        run_train("ovf300");

        arm = 1'b1;
        repeat (5) @(negedge clk);
        fill(2, 2, 2);
        send_pulses();
        arm = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_count", count, 2);
        send_pulses();
        check("abort_hold", count, 2);
        arm = 1'b1;
        @(negedge clk);
        check("rearm_count", count, 0);
        check("rearm_busy", busy, 1);
        disarm();

        lead = 4;
        fill(3, 2, IDLE_CYCLES - 2);
        run_train("edge_wins");
        fill(3, 2, IDLE_CYCLES - 1);
        run_train("edge_late");

        lead = 5;
        fill(3, 2, 2);
        hi_q.push_front(1);
        lo_q.push_front(3);
        run_train("glitch");

        for (int t = 0; t < 8; t++) begin
            lead = $urandom_range(1, 20);
            hi_q.delete();
            lo_q.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                hi_q.push_back($urandom_range(1, 3));
                lo_q.push_back($urandom_range(2, 15));
            end
            run_train($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
